// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, WIDTH+1 steps per product.
// Handles signed or unsigned operands, with abort and back-to-back start.
module booth_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             abort,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned EXT_W  = WIDTH + 1;
  localparam int unsigned PROD_W = 2 * EXT_W + 1;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, RUN} fsmState;

  fsmState            state, stateNext;
  logic               launch, finish;
  logic [CNT_W-1:0]   stepCount;
  logic [PROD_W-1:0]  pReg, pNext;
  logic [EXT_W-1:0]   aReg, sReg, addend, sum;
  logic [EXT_W-1:0]   extA, extB;

  // The extra top bit keeps the most-negative and all-ones operands representable
  assign extA = signed_op ? {InA[WIDTH-1], InA} : {1'b0, InA};
  assign extB = signed_op ? {InB[WIDTH-1], InB} : {1'b0, InB};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    launch    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          stateNext = RUN;
          launch    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (stepCount == CNT_W'(WIDTH)) begin
          stateNext = IDLE;
          finish    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // One Booth step: add/sub on the upper field, then arithmetic shift right
  always_comb begin
    addend = '0;
    case (pReg[1:0])
      2'b01:   addend = aReg;
      2'b10:   addend = sReg;
      default: addend = '0;
    endcase
    sum   = pReg[PROD_W-1:EXT_W+1] + addend;
    pNext = {sum[EXT_W-1], sum, pReg[EXT_W:1]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pReg      <= '0;
      aReg      <= '0;
      sReg      <= '0;
      stepCount <= '0;
      Hi        <= '0;
      Lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (stateNext == RUN);
      done <= finish;
      if (launch) begin
        aReg      <= extA;
        sReg      <= -extA;
        pReg      <= {EXT_W'(0), extB, 1'b0};
        stepCount <= '0;
      end else if (state == RUN && !abort) begin
        pReg      <= pNext;
        stepCount <= stepCount + CNT_W'(1);
        if (finish) begin
          Hi <= pNext[2*WIDTH:WIDTH+1];
          Lo <= pNext[WIDTH:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Bench for booth_multiplier: WIDTH=8/16/32 instances against an arithmetic product model.
module tb_booth_multiplier;

  localparam int NRAND = 300;

  logic clock = 1'b0;
  logic reset, start, signedOp, abort;
  logic [31:0] opA, opB;
  int sel;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  logic [7:0]  hi8, lo8;
  logic [15:0] hi16, lo16;
  logic [31:0] hi32, lo32;
  logic busy8, done8, busy16, done16, busy32, done32;
  logic start8, start16, start32, abort8, abort16, abort32;

  assign start8  = start && (sel == 0);
  assign start16 = start && (sel == 1);
  assign start32 = start && (sel == 2);
  assign abort8  = abort && (sel == 0);
  assign abort16 = abort && (sel == 1);
  assign abort32 = abort && (sel == 2);

  booth_multiplier #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_op(signedOp), .abort(abort8),
    .InA(opA[7:0]), .InB(opB[7:0]), .Hi(hi8), .Lo(lo8), .busy(busy8), .done(done8));
  booth_multiplier #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .signed_op(signedOp), .abort(abort16),
    .InA(opA[15:0]), .InB(opB[15:0]), .Hi(hi16), .Lo(lo16), .busy(busy16), .done(done16));
  booth_multiplier #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .signed_op(signedOp), .abort(abort32),
    .InA(opA), .InB(opB), .Hi(hi32), .Lo(lo32), .busy(busy32), .done(done32));

  logic [63:0] curProd;
  logic curBusy, curDone;

  // Selected instance, product re-assembled as {Hi,Lo}
  always_comb begin
    curProd = '0;
    curBusy = 1'b0;
    curDone = 1'b0;
    case (sel)
      0: begin curProd = 64'({hi8, lo8});   curBusy = busy8;  curDone = done8;  end
      1: begin curProd = 64'({hi16, lo16}); curBusy = busy16; curDone = done16; end
      default: begin curProd = {hi32, lo32}; curBusy = busy32; curDone = done32; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] refProduct(input int w, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, ea, eb;
    m  = (64'd1 << w) - 64'd1;
    ea = 64'(a) & m;
    eb = 64'(b) & m;
    if (sgn && ea[w-1]) ea = ea | ~m;
    if (sgn && eb[w-1]) eb = eb | ~m;
    return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic waitDone(input int lat0, output int lat);
    lat = lat0;
    while (!curDone && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic runOp(input int s, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] got, output int lat, output int busyCnt);
    sel = s; signedOp = sgn; opA = a; opB = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    busyCnt = 0;
    while (!curDone && lat < 100) begin
      busyCnt += 32'(curBusy);
      @(posedge clock); #1;
      lat++;
    end
    got = curProd;
  endtask

  initial begin
    logic [63:0] got;
    logic [31:0] a, b, m;
    int lat, busyCnt, w;
    logic sawDone;

    reset = 1'b0; start = 1'b0; abort = 1'b0; signedOp = 1'b0;
    opA = '0; opB = '0; sel = 2;
    #1;
    check("reset prod", curProd, 64'd0);
    check("reset busy/done", 64'({curBusy, curDone}), 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    runOp(2, 1'b1, 32'd7, 32'hFFFF_FFFD, got, lat, busyCnt);
    check("7*-3 prod", got, 64'hFFFF_FFFF_FFFF_FFEB);
    check("7*-3 latency", 64'(lat), 64'd33);
    check("7*-3 busy cycles", 64'(busyCnt), 64'd33);
    check("7*-3 busy after done", 64'(curBusy), 64'd0);

    runOp(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat, busyCnt);
    check("ones unsigned", got, 64'hFFFF_FFFE_0000_0001);
    runOp(2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat, busyCnt);
    check("ones signed", got, 64'h0000_0000_0000_0001);
    runOp(2, 1'b1, 32'h8000_0000, 32'h8000_0000, got, lat, busyCnt);
    check("minneg32", got, 64'h4000_0000_0000_0000);
    runOp(0, 1'b1, 32'h80, 32'h80, got, lat, busyCnt);
    check("minneg8", got, 64'h4000);
    check("latency8", 64'(lat), 64'd9);

    // Start re-pulsed mid-operation must be ignored
    sel = 2; signedOp = 1'b0; opA = 32'd5; opB = 32'd6; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    opA = 32'd100; opB = 32'd100; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    waitDone(10, lat);
    check("ignore start latency", 64'(lat), 64'd33);
    check("ignore start prod", curProd, 64'd30);

    // Back-to-back start during the done cycle
    opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b done drop", 64'(curDone), 64'd0);
    check("b2b busy", 64'(curBusy), 64'd1);
    repeat (15) begin @(posedge clock); #1; end
    check("b2b hold", curProd, 64'd30);
    waitDone(15, lat);
    check("b2b latency", 64'(lat), 64'd33);
    check("b2b prod", curProd, 64'd81);

    // Abort at step 5
    opA = 32'd3; opB = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort busy", 64'(curBusy), 64'd0);
    sawDone = 1'b0;
    repeat (40) begin @(posedge clock); #1; sawDone |= curDone; end
    check("abort no done", 64'(sawDone), 64'd0);
    check("abort hold", curProd, 64'd81);

    // Abort wins over start in IDLE
    abort = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0; start = 1'b0;
    check("abort+start idle", 64'(curBusy), 64'd0);

    // Reset mid-operation
    opA = 32'd11; opB = 32'd13; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    check("midreset prod", curProd, 64'd0);
    check("midreset busy/done", 64'({curBusy, curDone}), 64'd0);
    sawDone = 1'b0;
    repeat (3) begin @(posedge clock); #1; sawDone |= curDone; end
    reset = 1'b1;
    repeat (40) begin @(posedge clock); #1; sawDone |= curDone; end
    check("midreset no done", 64'(sawDone), 64'd0);
    runOp(2, 1'b0, 32'd2, 32'd3, got, lat, busyCnt);
    check("after reset prod", got, 64'd6);

    // Random regression per width and mode
    for (int s = 0; s < 3; s++) begin
      w = 8 << s;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      for (int sg = 0; sg < 2; sg++) begin
        repeat (NRAND) begin
          a = $urandom & m;
          b = $urandom & m;
          case ($urandom_range(0, 7))
            0: a = m;
            1: b = 32'd1 << (w - 1);
            2: begin a = 32'd1 << (w - 1); b = a; end
            default: ;
          endcase
          runOp(s, sg[0], a, b, got, lat, busyCnt);
          check($sformatf("rand w%0d s%0d %h*%h", w, sg, a, b), got, refProduct(w, sg[0], a, b));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
